// File: rtl/kmeans_point_buffer_if.sv
// Handshake and status bundle between the sample source/sink and the point buffer.
// The slave side is the buffer; the master side drives samples and consumes replays.
interface kmeans_point_buffer_if #(
    parameter int DW = 16,
    parameter int AW = 12
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          rd_start;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [AW:0]   frame_cnt;
    logic          busy;
    logic          overflow;

    modport master (
        output in_valid, in_data, rd_start, out_ready,
        input  out_valid, out_data, out_last, frame_cnt, busy, overflow
    );

    modport slave (
        input  in_valid, in_data, rd_start, out_ready,
        output out_valid, out_data, out_last, frame_cnt, busy, overflow
    );
endinterface

// File: rtl/kmeans_point_buffer.sv
// Captures one burst of samples into on-chip RAM and replays the whole frame,
// in capture order, once per rd_start pulse.
//
// state | meaning
// IDLE  | no frame captured since reset; rd_start ignored
// LOAD  | burst in progress, writing samples at wr_ptr
// HOLD  | frame stored; waits for rd_start (replay) or in_valid (new frame)
// PLAY  | replaying the frame; inputs ignored until the last handshake
module kmeans_point_buffer #(
    parameter int DW    = 16,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    kmeans_point_buffer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, HOLD, PLAY} state_t;

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE       = (AW+1)'(1);

    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [AW:0]   frame_cnt;
    logic          busy;
    logic          overflow;

    // The first sample of a burst goes to address 0 from IDLE/HOLD; a full
    // buffer simply stops accepting writes.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (!rst && bus.in_valid) begin
            case (state)
                IDLE, HOLD: wr_en = 1'b1;
                LOAD: begin
                    wr_en   = (wr_ptr != DEPTH_CNT);
                    wr_addr = wr_ptr[AW-1:0];
                end
                default: wr_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.in_data;
        end
    end

    // out_data is the RAM read register itself, so a stall just withholds the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (bus.in_valid) begin
                        state    <= LOAD;
                        wr_ptr   <= ONE;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                    end else if (state == HOLD && bus.rd_start && frame_cnt != '0) begin
                        state  <= PLAY;
                        rd_ptr <= '0;
                        busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        if (wr_ptr == DEPTH_CNT) begin
                            overflow <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + ONE;
                        end
                    end else begin
                        state     <= HOLD;
                        frame_cnt <= wr_ptr;
                        busy      <= 1'b0;
                    end
                end
                PLAY: begin
                    if (out_valid && bus.out_ready && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= HOLD;
                        busy      <= 1'b0;
                    end else if (!out_valid || bus.out_ready) begin
                        out_data  <= mem[rd_ptr[AW-1:0]];
                        out_valid <= 1'b1;
                        out_last  <= (rd_ptr == frame_cnt - ONE);
                        rd_ptr    <= rd_ptr + ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
    assign bus.frame_cnt = frame_cnt;
    assign bus.busy      = busy;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_kmeans_point_buffer.sv
// Directed bench for kmeans_point_buffer: a frame model feeds an expected-output
// queue at each rd_start, and a negedge monitor pops and compares on every handshake.
module tb_kmeans_point_buffer;
    localparam int DW    = 16;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kmeans_point_buffer_if #(.DW(DW), .AW(AW)) bus();

    kmeans_point_buffer #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            n_cmp      = 0;
    int            n_err      = 0;
    int            n_spurious = 0;
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] frame[$];
    logic [DW-1:0] stim[$];
    logic          stall_prev = 1'b0;
    logic [DW:0]   stall_word = '0;
    logic [DW:0]   e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_stim();
        frame.delete();
        foreach (stim[i]) begin
            bus.in_valid = 1'b1;
            bus.in_data  = stim[i];
            if (i < DEPTH) frame.push_back(stim[i]);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic start_pass();
        foreach (frame[i]) exp_q.push_back({(i == frame.size() - 1), frame[i]});
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
    endtask

    // mode 1 throttles out_ready with the repeating pattern 1,0,0,1
    task automatic drain(input int mode, input int budget);
        int cyc = 0;
        while ((exp_q.size() != 0 || bus.busy) && cyc < budget) begin
            if (mode == 1) bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            tick();
            cyc++;
        end
        bus.out_ready = 1'b1;
        check("drain_left", exp_q.size(), 0);
        check("drain_busy", bus.busy, 0);
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.out_valid) cnt++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_hold", {bus.out_last, bus.out_data}, stall_word);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_spurious++;
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e[DW-1:0]);
                    check("out_last", bus.out_last, e[DW]);
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_word = {bus.out_last, bus.out_data};
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        int cnt;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.rd_start  = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data, 0);
        check("rst_out_last",  bus.out_last, 0);
        check("rst_frame_cnt", bus.frame_cnt, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_overflow",  bus.overflow, 0);
        rst = 1'b0;
        tick();

        // rd_start with nothing loaded
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        count_valid(20, cnt);
        check("idle_no_output", cnt, 0);
        check("idle_busy", bus.busy, 0);

        // two-sample frame with exact latency
        stim = '{16'd1024, 16'd512};
        load_stim();
        check("t1_frame_cnt", bus.frame_cnt, 2);
        check("t1_busy_hold", bus.busy, 0);
        start_pass();
        check("t1_lat_gap", bus.out_valid, 0);
        check("t1_busy_play", bus.busy, 1);
        tick();
        check("t1_v0", bus.out_valid, 1);
        check("t1_d0", bus.out_data, 1024);
        check("t1_l0", bus.out_last, 0);
        tick();
        check("t1_v1", bus.out_valid, 1);
        check("t1_d1", bus.out_data, 512);
        check("t1_l1", bus.out_last, 1);
        tick();
        check("t1_v_end", bus.out_valid, 0);
        check("t1_busy_end", bus.busy, 0);

        // three more passes of the same frame
        for (int p = 0; p < 3; p++) begin
            start_pass();
            drain(0, 20);
        end

        // new burst replaces the frame; throttled replay
        stim = '{16'd10, 16'd20, 16'd30, 16'd40};
        load_stim();
        check("t3_frame_cnt", bus.frame_cnt, 4);
        start_pass();
        drain(1, 40);

        // in_valid and rd_start during PLAY are ignored
        start_pass();
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hbad0;
        tick();
        tick();
        bus.in_valid = 1'b0;
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        drain(0, 20);
        check("play_ign_frame_cnt", bus.frame_cnt, 4);
        start_pass();
        drain(0, 20);

        // in_valid beats rd_start in the same HOLD cycle
        bus.rd_start = 1'b1;
        stim = '{16'd99, 16'd98};
        load_stim();
        bus.rd_start = 1'b0;
        count_valid(5, cnt);
        check("tie_no_output", cnt, 0);
        check("tie_frame_cnt", bus.frame_cnt, 2);
        start_pass();
        drain(0, 20);

        // overflow burst
        stim.delete();
        for (int i = 0; i < DEPTH + 3; i++) stim.push_back(DW'(i * 7 + 3));
        load_stim();
        check("ovf_frame_cnt", bus.frame_cnt, DEPTH);
        check("ovf_flag", bus.overflow, 1);
        start_pass();
        drain(0, DEPTH + 20);
        check("ovf_flag_after_play", bus.overflow, 1);
        stim = '{16'd5, 16'd6, 16'd7};
        load_stim();
        check("ovf_cleared", bus.overflow, 0);
        check("ovf_new_cnt", bus.frame_cnt, 3);
        start_pass();
        drain(0, 20);

        // single-sample frame carries out_last on its only sample
        stim = '{16'd7};
        load_stim();
        check("one_frame_cnt", bus.frame_cnt, 1);
        start_pass();
        tick();
        check("one_valid", bus.out_valid, 1);
        check("one_data", bus.out_data, 7);
        check("one_last", bus.out_last, 1);
        tick();
        check("one_end", bus.out_valid, 0);

        // reset mid-PLAY
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(DW'(16'h100 + i));
        load_stim();
        start_pass();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rstplay_valid", bus.out_valid, 0);
        check("rstplay_frame_cnt", bus.frame_cnt, 0);
        check("rstplay_busy", bus.busy, 0);
        exp_q.delete();
        rst = 1'b0;
        tick();
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        count_valid(20, cnt);
        check("rstplay_no_output", cnt, 0);

        check("spurious_outputs", n_spurious, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
